i2c_target_wr: RTL and testbench
================================

// Module: i2c_target_wr
// PURPOSE
//  I2C target (slave) for the write transactions our I2C master issues: START, 7-bit address+R/W,
//  register address byte, one or more data bytes, STOP. Each byte is ACKed or NACKed by pulling SDA
//  open-drain. Each accepted data byte goes out as a {reg_addr,data} word on a valid/ready port to the
//  local register file. Runs on a fast system clock that oversamples SCL/SDA; it never drives SCL.
// PARAMETERS
//  TARGET_ADDR  7'h42  7-bit address this target responds to
//  SYNC_STAGES  2      synchroniser flops on SCL/SDA inputs (>=2)
// PORTS
//  clk          in     1  system clock; must be >= 8x SCL frequency
//  rst_n        in     1  reset, synchronous, active-low
//  i2c_scl      in     1  I2C clock from the master
//  i2c_sda      inout  1  I2C data; driven only 0 or 'z (open drain)
//  wr_reg_addr  out    8  register address of the delivered byte
//  wr_data      out    8  delivered data byte
//  wr_valid     out    1  {wr_reg_addr,wr_data} valid; held until accepted
//  wr_ready     in     1  consumer accepts when wr_valid & wr_ready
//  busy         out    1  high from START until STOP
//  overflow     out    1  1-cycle pulse: data byte NACKed because the output slot was full
//  error        out    1  sticky: address NACK (R/W=1), bus error or overflow; cleared by next START
// BEHAVIOUR
//  Reset (rst_n=0 at posedge clk): state=IDLE, SDA released ('z), wr_valid=0, busy=0, overflow=0,
//   error=0, wr_reg_addr=0, wr_data=0, bit counter=0.
//  Input path: SCL/SDA pass SYNC_STAGES flops, then one edge-detect flop. Detected events lag the pins
//   by SYNC_STAGES+1 clks. scl_rise/scl_fall are single-cycle pulses.
//   START = SDA fall while SCL high. STOP = SDA rise while SCL high. Both are checked every cycle, in
//   every state, and override everything else.
//  Data bits are sampled on scl_rise, MSB first. SDA drive changes only on scl_fall.
//  FSM (bit counter 0..7; byte done when bit 7 is sampled):
//   IDLE     -> ADDR on START. busy=1, error cleared.
//   ADDR     8 bits {addr[6:0],rw}. At byte done: match & rw=0 -> ACK_A.
//            Mismatch -> IGNORE (no ACK, error unchanged). Match & rw=1 -> IGNORE, error=1 (reads unsupported).
//   ACK_A    pull SDA low from the next scl_fall until the following scl_fall; then -> REG.
//   REG      8 bits captured into the address pointer; byte done -> ACK_R (always ACK) -> DATA.
//   DATA     8 bits. At byte done: slot empty -> load wr_data and wr_reg_addr=pointer, wr_valid=1 the next
//            clk, -> ACK_D. Slot full -> drop the byte, overflow pulse, error=1, -> NACK_D (SDA released).
//   ACK_D/NACK_D  one SCL period as in ACK_A, then -> DATA. After ACK_D the pointer increments
//            (8-bit wrap, 8'hFF -> 8'h00).
//   IGNORE   SDA released; wait for START or STOP.
//   STOP in any state -> IDLE, busy=0, SDA released in the same cycle. A partial byte is discarded.
//   START in any non-IDLE state (repeated start) -> ADDR, counter=0, pointer kept. A pending wr_valid is unaffected.
//  Bus error: START or STOP detected mid-byte (counter 1..7) in REG or DATA -> error=1, then the normal
//   STOP/START transition.
//  Output slot: one entry. wr_valid falls the cycle after the wr_valid&wr_ready handshake. If wr_ready is
//   high in the same cycle as a byte done, the slot counts as freed and the new byte is ACKed.
//   wr_reg_addr/wr_data are stable while wr_valid=1.
//  rst_n low mid-transfer: immediate return to reset values, SDA released, pending word lost; the
//   target then waits for the next START (a STOP alone does not re-arm).
// STRUCTURE
//  Package i2c_pkg: typedef enum i2c_tgt_state_t {IDLE,ADDR,ACK_A,REG,ACK_R,DATA,ACK_D,NACK_D,IGNORE};
//   localparam I2C_RW_WRITE=1'b0; shared with the master.
//  Sub-module i2c_line_sync: synchroniser + edge detect; outputs scl_rise, scl_fall, start_det, stop_det,
//   sda_s. Top level holds the FSM, shift register, pointer, output slot and open-drain SDA assign.
// TESTING (bench models a master plus pull-up, SCL = clk/16)
//  1 Write addr 7'h42, reg 8'h10, data 8'hA5, STOP -> 3 ACKs; one handshake {8'h10,8'hA5}; busy falls at STOP.
//  2 Burst reg 8'hFE, data 11,22,33, wr_ready=1 -> words {FE,11},{FF,22},{00,33} (pointer wrap).
//  3 Address 7'h43 -> SDA never pulled low; no wr_valid; error=0; busy until STOP.
//  4 Address 7'h42 with rw=1 -> address NACK; error=1; then a new START+write clears error and succeeds.
//  5 wr_ready=0, two data bytes -> first ACKed and held; second NACKed, overflow pulse, error=1.
//  6 STOP after 4 data bits; then rst_n=0 mid-address -> no word delivered; SDA 'z; next full write works.

Source files
------------

// File: rtl/i2c_pkg.sv
// Purpose: shared I2C types and constants for the target (and the matching master).
//   i2c_tgt_state_t : target protocol state
//   I2C_RW_WRITE    : value of the R/W bit for a write transfer
package i2c_pkg;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ACK_A,
      REG,
      ACK_R,
      DATA,
      ACK_D,
      NACK_D,
      IGNORE
   } i2c_tgt_state_t;

   localparam logic I2C_RW_WRITE = 1'b0;

endpackage

// File: rtl/i2c_line_sync.sv
// Purpose: synchronise SCL/SDA into clk and detect bus events.
// Ports:
//   clk, rst_n          system clock, synchronous active-low reset
//   scl, sda            raw bus pins
//   scl_rise, scl_fall  one-cycle SCL edge pulses
//   start_det, stop_det one-cycle START / STOP pulses
//   sda_s               SDA value aligned with the event pulses
module i2c_line_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic scl,
   input  logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic sda_s
);

   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl_d;
   logic                   sda_d;
   logic                   scl_m;
   logic                   sda_m;

   assign scl_m = scl_sync[SYNC_STAGES-1];
   assign sda_m = sda_sync[SYNC_STAGES-1];

   // Synchroniser chain plus one registered edge-detect stage; idle bus is high.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scl_sync  <= '1;
         sda_sync  <= '1;
         scl_d     <= 1'b1;
         sda_d     <= 1'b1;
         scl_rise  <= 1'b0;
         scl_fall  <= 1'b0;
         start_det <= 1'b0;
         stop_det  <= 1'b0;
         sda_s     <= 1'b1;
      end else begin
         scl_sync  <= {scl_sync[SYNC_STAGES-2:0], scl};
         sda_sync  <= {sda_sync[SYNC_STAGES-2:0], sda};
         scl_d     <= scl_m;
         sda_d     <= sda_m;
         scl_rise  <= scl_m & ~scl_d;
         scl_fall  <= ~scl_m & scl_d;
         // SDA edge while SCL is stably high is a bus condition, not data.
         start_det <= ~sda_m & sda_d & scl_m & scl_d;
         stop_det  <= sda_m & ~sda_d & scl_m & scl_d;
         sda_s     <= sda_m;
      end
   end

endmodule

// File: rtl/i2c_target_wr.sv
// Purpose: I2C write-only target; delivers {reg_addr,data} words on a valid/ready port.
// Ports:
//   clk, rst_n               system clock (>= 8x SCL), synchronous active-low reset
//   i2c_scl, i2c_sda         I2C bus; SDA is open drain (0 or 'z only)
//   wr_reg_addr, wr_data     delivered word, stable while wr_valid
//   wr_valid, wr_ready       output handshake
//   busy                     START..STOP
//   overflow                 one-cycle pulse when a data byte is NACKed for a full slot
//   error                    sticky error flag, cleared by the next START
module i2c_target_wr
   import i2c_pkg::*;
#(
   parameter logic [6:0]  TARGET_ADDR = 7'h42,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i2c_scl,
   inout  wire        i2c_sda,
   output logic [7:0] wr_reg_addr,
   output logic [7:0] wr_data,
   output logic       wr_valid,
   input  logic       wr_ready,
   output logic       busy,
   output logic       overflow,
   output logic       error
);

   i2c_tgt_state_t state;
   logic [2:0]     bit_cnt;
   logic [6:0]     shift;
   logic [7:0]     ptr;
   logic           sda_low;
   logic           ack_started;

   logic scl_rise, scl_fall, start_det, stop_det, sda_s;
   logic [7:0] byte_c;
   logic       slot_free_c;
   logic       mid_byte_c;

   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .scl       (i2c_scl),
      .sda       (i2c_sda),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det),
      .sda_s     (sda_s)
   );

   assign i2c_sda     = sda_low ? 1'b0 : 1'bz;
   assign byte_c      = {shift, sda_s};
   // A handshake in the same cycle frees the slot for the incoming byte.
   assign slot_free_c = ~wr_valid | wr_ready;
   assign mid_byte_c  = ((state == REG) || (state == DATA)) && (bit_cnt != 3'd0);

   // Protocol FSM, shifter, pointer and output slot.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         bit_cnt     <= 3'd0;
         shift       <= 7'd0;
         ptr         <= 8'd0;
         sda_low     <= 1'b0;
         ack_started <= 1'b0;
         wr_reg_addr <= 8'd0;
         wr_data     <= 8'd0;
         wr_valid    <= 1'b0;
         busy        <= 1'b0;
         overflow    <= 1'b0;
         error       <= 1'b0;
      end else begin
         overflow <= 1'b0;
         if (wr_valid && wr_ready) wr_valid <= 1'b0;

         if (start_det || stop_det) begin
            // Bus conditions win over everything; a truncated byte is dropped.
            bit_cnt     <= 3'd0;
            sda_low     <= 1'b0;
            ack_started <= 1'b0;
            if (stop_det) begin
               state <= IDLE;
               busy  <= 1'b0;
               if (mid_byte_c) error <= 1'b1;
            end else begin
               state <= ADDR;
               busy  <= 1'b1;
               error <= mid_byte_c;
            end
         end else begin
            case (state)
               ADDR, REG, DATA: begin
                  if (scl_rise) begin
                     shift   <= byte_c[6:0];
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        ack_started <= 1'b0;
                        case (state)
                           ADDR: begin
                              if (byte_c[7:1] != TARGET_ADDR) begin
                                 state <= IGNORE;
                              end else if (byte_c[0] == I2C_RW_WRITE) begin
                                 state <= ACK_A;
                              end else begin
                                 state <= IGNORE;
                                 error <= 1'b1;
                              end
                           end
                           REG: begin
                              ptr   <= byte_c;
                              state <= ACK_R;
                           end
                           default: begin
                              if (slot_free_c) begin
                                 wr_data     <= byte_c;
                                 wr_reg_addr <= ptr;
                                 wr_valid    <= 1'b1;
                                 state       <= ACK_D;
                              end else begin
                                 overflow <= 1'b1;
                                 error    <= 1'b1;
                                 state    <= NACK_D;
                              end
                           end
                        endcase
                     end
                  end
               end
               ACK_A, ACK_R, ACK_D, NACK_D: begin
                  // First SCL fall starts the ninth bit, second one ends it.
                  if (scl_fall) begin
                     if (!ack_started) begin
                        ack_started <= 1'b1;
                        sda_low     <= (state != NACK_D);
                     end else begin
                        ack_started <= 1'b0;
                        sda_low     <= 1'b0;
                        state       <= (state == ACK_A) ? REG : DATA;
                        if (state == ACK_D) ptr <= ptr + 8'd1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_target_wr.sv
// Purpose: directed bench for i2c_target_wr with a bit-banged master and SDA pull-up.
// SCL runs at clk/16; master changes SDA mid-way through SCL low.
module tb_i2c_target_wr;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       scl;
   logic       m_low;
   logic       wr_ready;
   wire        sda;
   logic [7:0] wr_reg_addr, wr_data;
   logic       wr_valid, busy, overflow, error;

   int tests = 0;
   int fails = 0;
   int tlow = 0;
   int ovf_cnt = 0;
   logic [15:0] words[$];
   logic ack;

   always #5 clk = ~clk;

   pullup (sda);
   assign sda = m_low ? 1'b0 : 1'bz;

   i2c_target_wr #(.TARGET_ADDR(7'h42), .SYNC_STAGES(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i2c_scl     (scl),
      .i2c_sda     (sda),
      .wr_reg_addr (wr_reg_addr),
      .wr_data     (wr_data),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .busy        (busy),
      .overflow    (overflow),
      .error       (error)
   );

   // Monitor: values seen here are those in effect at the next posedge.
   always @(negedge clk) begin
      #1;
      if (rst_n && wr_valid && wr_ready) words.push_back({wr_reg_addr, wr_data});
      if (overflow) ovf_cnt++;
      if (!m_low && sda !== 1'b1) tlow++;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_word(input string tag, input logic [15:0] exp);
      logic [15:0] w;
      if (words.size() > 0) w = words.pop_front();
      else w = 16'hDEAD;
      check(tag, w, exp);
   endtask

   task automatic i2c_start();
      tick(4); m_low = 1'b0;
      tick(4); scl = 1'b1;
      tick(8); m_low = 1'b1;
      tick(8); scl = 1'b0;
   endtask

   task automatic i2c_stop();
      tick(4); m_low = 1'b1;
      tick(4); scl = 1'b1;
      tick(8); m_low = 1'b0;
      tick(8);
   endtask

   task automatic write_bit(input logic b);
      tick(4); m_low = ~b;
      tick(4); scl = 1'b1;
      tick(8); scl = 1'b0;
   endtask

   task automatic read_ack(output logic a);
      tick(4); m_low = 1'b0;
      tick(4); scl = 1'b1;
      tick(4); a = (sda === 1'b0);
      tick(4); scl = 1'b0;
   endtask

   task automatic write_byte(input logic [7:0] b, output logic a);
      for (int i = 7; i >= 0; i--) write_bit(b[i]);
      read_ack(a);
   endtask

   initial begin
      rst_n = 1'b0; scl = 1'b1; m_low = 1'b0; wr_ready = 1'b0;
      tick(4);
      check("rst_valid", 16'(wr_valid), 16'd0);
      check("rst_busy", 16'(busy), 16'd0);
      check("rst_ovf", 16'(overflow), 16'd0);
      check("rst_err", 16'(error), 16'd0);
      check("rst_word", {wr_reg_addr, wr_data}, 16'h0000);
      check("rst_sda", 16'(sda), 16'd1);
      rst_n = 1'b1;
      tick(4);

      // 1: single write
      wr_ready = 1'b1;
      i2c_start();
      check("t1_busy", 16'(busy), 16'd1);
      write_byte(8'h84, ack); check("t1_ack_addr", 16'(ack), 16'd1);
      write_byte(8'h10, ack); check("t1_ack_reg", 16'(ack), 16'd1);
      write_byte(8'hA5, ack); check("t1_ack_data", 16'(ack), 16'd1);
      i2c_stop();
      check("t1_busy_end", 16'(busy), 16'd0);
      check("t1_count", 16'(words.size()), 16'd1);
      check_word("t1_word", 16'h10A5);

      // 2: burst with pointer wrap
      i2c_start();
      write_byte(8'h84, ack);
      write_byte(8'hFE, ack);
      write_byte(8'h11, ack); check("t2_ack1", 16'(ack), 16'd1);
      write_byte(8'h22, ack); check("t2_ack2", 16'(ack), 16'd1);
      write_byte(8'h33, ack); check("t2_ack3", 16'(ack), 16'd1);
      i2c_stop();
      check("t2_count", 16'(words.size()), 16'd3);
      check_word("t2_w0", 16'hFE11);
      check_word("t2_w1", 16'hFF22);
      check_word("t2_w2", 16'h0033);

      // 3: other address is ignored
      tlow = 0;
      i2c_start();
      write_byte(8'h86, ack); check("t3_nack", 16'(ack), 16'd0);
      write_byte(8'h10, ack);
      check("t3_busy", 16'(busy), 16'd1);
      check("t3_err", 16'(error), 16'd0);
      check("t3_sda_low", 16'(tlow), 16'd0);
      i2c_stop();
      check("t3_busy_end", 16'(busy), 16'd0);
      check("t3_count", 16'(words.size()), 16'd0);

      // 4: read request NACKed, then a write clears error
      i2c_start();
      write_byte(8'h85, ack); check("t4_nack", 16'(ack), 16'd0);
      check("t4_err", 16'(error), 16'd1);
      i2c_stop();
      check("t4_err_sticky", 16'(error), 16'd1);
      i2c_start();
      check("t4_err_clr", 16'(error), 16'd0);
      write_byte(8'h84, ack); check("t4_ack", 16'(ack), 16'd1);
      write_byte(8'h05, ack);
      write_byte(8'hC3, ack);
      i2c_stop();
      check_word("t4_word", 16'h05C3);

      // 5: full slot overflow
      wr_ready = 1'b0; ovf_cnt = 0;
      i2c_start();
      write_byte(8'h84, ack);
      write_byte(8'h20, ack);
      write_byte(8'h5A, ack); check("t5_ack1", 16'(ack), 16'd1);
      write_byte(8'h6B, ack); check("t5_nack2", 16'(ack), 16'd0);
      check("t5_ovf", 16'(ovf_cnt), 16'd1);
      check("t5_err", 16'(error), 16'd1);
      check("t5_valid", 16'(wr_valid), 16'd1);
      check("t5_held", {wr_reg_addr, wr_data}, 16'h205A);
      i2c_stop();
      wr_ready = 1'b1;
      tick(4);
      check("t5_drained", 16'(wr_valid), 16'd0);
      check("t5_count", 16'(words.size()), 16'd1);
      check_word("t5_word", 16'h205A);

      // 6: truncated byte, then reset mid-address, then recovery
      i2c_start();
      write_byte(8'h84, ack);
      write_byte(8'h30, ack);
      write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
      i2c_stop();
      check("t6_bus_err", 16'(error), 16'd1);
      check("t6_busy", 16'(busy), 16'd0);
      check("t6_no_word", 16'(words.size()), 16'd0);
      i2c_start();
      write_bit(1'b1); write_bit(1'b0); write_bit(1'b0);
      rst_n = 1'b0;
      tick(2);
      check("t6_rst_busy", 16'(busy), 16'd0);
      check("t6_rst_err", 16'(error), 16'd0);
      m_low = 1'b0;
      tick(1);
      check("t6_rst_sda", 16'(sda), 16'd1);
      rst_n = 1'b1;
      write_bit(1'b0); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0); write_bit(1'b0);
      read_ack(ack); check("t6_no_rearm", 16'(ack), 16'd0);
      check("t6_idle", 16'(busy), 16'd0);
      i2c_stop();
      i2c_start();
      write_byte(8'h84, ack); check("t6_ack_addr", 16'(ack), 16'd1);
      write_byte(8'h40, ack);
      write_byte(8'h77, ack); check("t6_ack_data", 16'(ack), 16'd1);
      i2c_stop();
      check("t6_count", 16'(words.size()), 16'd1);
      check_word("t6_word", 16'h4077);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
